// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: PC-controller redirect, instruction-memory
// req/gnt/rvalid port and the instruction handoff to ID.
interface instr_fetch_if #(
    parameter int WIDTH = 32
);
    logic             redirect_i;
    logic [WIDTH-1:0] next_pc_i;
    logic [WIDTH-1:0] fetch_pc_o;
    logic             imem_req_o;
    logic [WIDTH-1:0] imem_addr_o;
    logic             imem_gnt_i;
    logic             imem_rvalid_i;
    logic [WIDTH-1:0] imem_rdata_i;
    logic             valid_o;
    logic [WIDTH-1:0] instr_o;
    logic [WIDTH-1:0] pc_o;
    logic             ready_id_i;

    modport master (
        input  redirect_i, next_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_id_i,
        output fetch_pc_o, imem_req_o, imem_addr_o, valid_o, instr_o, pc_o
    );

    modport slave (
        output redirect_i, next_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_id_i,
        input  fetch_pc_o, imem_req_o, imem_addr_o, valid_o, instr_o, pc_o
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem request, {instr, pc} buffer toward ID,
// flush on redirect with the in-flight response tagged for discard.
module ifu_buf_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_o
);
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc_q;

    // Payload only; occupancy lives in the parent, so no reset is needed here.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
endmodule

module instr_fetch_unit #(
    parameter int               WIDTH      = 32,
    parameter int               FIFO_DEPTH = 2,
    parameter logic [WIDTH-1:0] BOOT_ADDR  = '0
) (
    input logic              clk_i,
    input logic              rst_i,
    instr_fetch_if.master    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             out_q, out_d;
    logic             kill_q, kill_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic             in_flight;
    logic [CNT_W-1:0] occupancy;
    logic             req, grant, resp, push, pop;

    logic [FIFO_DEPTH-1:0]            wr_en;
    logic [FIFO_DEPTH-1:0][WIDTH-1:0] ent_instr;
    logic [FIFO_DEPTH-1:0][WIDTH-1:0] ent_pc;

    // A live (non-killed) outstanding request already owns a buffer slot.
    always_comb begin
        in_flight = out_q && !kill_q;
        occupancy = count_q + CNT_W'(in_flight);
        req   = !rst_i && !bus.redirect_i && (!out_q || bus.imem_rvalid_i)
                && (occupancy < CNT_W'(FIFO_DEPTH));
        grant = req && bus.imem_gnt_i;
        resp  = out_q && bus.imem_rvalid_i;
        push  = resp && !kill_q && !bus.redirect_i;
        pop   = valid_q && bus.ready_id_i && !bus.redirect_i;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        out_d      = out_q;
        kill_d     = kill_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (resp) begin
            out_d  = 1'b0;
            kill_d = 1'b0;
        end
        if (grant) begin
            out_d      = 1'b1;
            kill_d     = 1'b0;
            pend_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + WIDTH'(4);
        end

        // Redirect wins over push/pop; a response still in the air gets killed.
        if (bus.redirect_i) begin
            fetch_pc_d = bus.next_pc_i;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            if (out_q && !bus.imem_rvalid_i) kill_d = 1'b1;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= BOOT_ADDR;
            pend_pc_q  <= '0;
            out_q      <= 1'b0;
            kill_q     <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            out_q      <= out_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_buf
        assign wr_en[i] = push && (wr_ptr_q == PTR_W'(i));
        ifu_buf_entry #(.WIDTH(WIDTH)) u_ent (
            .clk_i   (clk_i),
            .we_i    (wr_en[i]),
            .instr_i (bus.imem_rdata_i),
            .pc_i    (pend_pc_q),
            .instr_o (ent_instr[i]),
            .pc_o    (ent_pc[i])
        );
    end

    assign bus.fetch_pc_o  = fetch_pc_q;
    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = fetch_pc_q;
    assign bus.valid_o     = valid_q;
    assign bus.instr_o     = ent_instr[rd_ptr_q];
    assign bus.pc_o        = ent_pc[rd_ptr_q];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: queue-based fetch model plus an
// in-order ID stream check, pinned by directed literal expectations.
module tb_instr_fetch_unit;
    localparam int          W     = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.WIDTH(W)) bus ();

    instr_fetch_unit #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // stimulus knobs
    logic        d_rst, d_redirect, d_gnt, d_ready;
    logic [31:0] d_next_pc;
    int          lat_lo, lat_hi;

    // memory responder
    bit          r_pend;
    logic [31:0] r_addr;
    int          r_wait;

    // reference model
    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc, m_pend, s_pc;
    bit          m_out, m_kill;

    task automatic model_reset();
        m_q.delete();
        m_pc   = BOOT;
        s_pc   = BOOT;
        m_out  = 0;
        m_kill = 0;
        r_pend = 0;
    endtask

    task automatic check_update();
        bit          rv, e_req, pop, resp, gr;
        logic [31:0] req_addr;
        rv    = bus.imem_rvalid_i;
        e_req = !rst && !d_redirect && (!m_out || rv)
                && ((m_q.size() + int'(m_out && !m_kill)) < DEPTH);
        chk("imem_req_o", bus.imem_req_o, e_req);
        chk("fetch_pc_o", bus.fetch_pc_o, m_pc);
        if (e_req) chk("imem_addr_o", bus.imem_addr_o, m_pc);
        chk("valid_o", bus.valid_o, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("pc_o", bus.pc_o, m_q[0].pc);
            chk("instr_o", bus.instr_o, m_q[0].instr);
        end
        chk("rvalid_protocol", rv && !m_out, 0);
        if (rst) begin
            model_reset();
            return;
        end
        pop = (m_q.size() != 0) && d_ready && !d_redirect;
        if (pop) begin
            chk("stream_pc", bus.pc_o, s_pc);
            chk("stream_instr", bus.instr_o, mem_word(bus.pc_o));
            s_pc = s_pc + 32'd4;
        end
        resp     = rv && m_out;
        gr       = e_req && d_gnt;
        req_addr = m_pc;
        if (d_redirect) begin
            m_q.delete();
            m_pc   = d_next_pc;
            s_pc   = d_next_pc;
            m_kill = m_out && !rv;
            if (resp) m_out = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (resp) begin
                if (!m_kill) m_q.push_back(ent_t'{instr: bus.imem_rdata_i, pc: m_pend});
                m_kill = 0;
                m_out  = 0;
            end
            if (gr) begin
                m_out  = 1;
                m_kill = 0;
                m_pend = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
        if (rv) r_pend = 0;
        else if (r_pend && r_wait > 0) r_wait--;
        if (gr) begin
            r_pend = 1;
            r_addr = req_addr;
            r_wait = int'($urandom_range(lat_hi, lat_lo));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst               = d_rst;
        bus.redirect_i    = d_redirect;
        bus.next_pc_i     = d_next_pc;
        bus.imem_gnt_i    = d_gnt;
        bus.ready_id_i    = d_ready;
        bus.imem_rvalid_i = r_pend && (r_wait == 0);
        bus.imem_rdata_i  = bus.imem_rvalid_i ? mem_word(r_addr) : $urandom;
        @(negedge clk);
        check_update();
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.valid_o && k < 20) begin
            step();
            k++;
        end
        chk("wait_valid", bus.valid_o, 1);
    endtask

    initial begin
        logic [31:0] a0;
        int          k;
        d_rst = 1; d_redirect = 0; d_gnt = 0; d_ready = 0; d_next_pc = '0;
        lat_lo = 0; lat_hi = 0;
        bus.redirect_i = 0; bus.next_pc_i = '0; bus.imem_gnt_i = 0;
        bus.imem_rvalid_i = 0; bus.imem_rdata_i = '0; bus.ready_id_i = 0;
        model_reset();
        #1 rst = 1;
        #1;
        chk("reset_req", bus.imem_req_o, 0);
        chk("reset_valid", bus.valid_o, 0);
        chk("reset_fetch_pc", bus.fetch_pc_o, BOOT);
        step(); step();
        d_rst = 0;

        // streaming from boot, immediate gnt, 1-cycle rvalid
        d_gnt = 1; d_ready = 1;
        step(); chk("t1_req0", bus.imem_req_o, 1); chk("t1_addr0", bus.imem_addr_o, 32'h0);
                chk("t1_valid0", bus.valid_o, 0);
        step(); chk("t1_addr1", bus.imem_addr_o, 32'h4); chk("t1_valid1", bus.valid_o, 0);
        step(); chk("t1_valid2", bus.valid_o, 1); chk("t1_pc2", bus.pc_o, 32'h0);
                chk("t1_instr2", bus.instr_o, mem_word(32'h0));
        step(); chk("t1_pc3", bus.pc_o, 32'h4);

        // ID stalls: buffer fills, request drops, resumes after one pop
        d_ready = 0;
        repeat (4) step();
        chk("t2_full_req", bus.imem_req_o, 0); chk("t2_full_valid", bus.valid_o, 1);
        d_ready = 1; step(); chk("t2_pop_req", bus.imem_req_o, 0);
        d_ready = 0; step(); chk("t2_resume_req", bus.imem_req_o, 1);
        d_ready = 1;

        // redirect while a slow response is outstanding
        lat_lo = 3; lat_hi = 3;
        k = 0;
        while (!(m_out && r_pend && r_wait > 0) && k < 20) begin step(); k++; end
        chk("t3_outstanding", k < 20, 1);
        d_redirect = 1; d_next_pc = 32'h100; step();
        d_redirect = 0; step(); chk("t3_valid_r1", bus.valid_o, 0);
        wait_valid(); chk("t3_first_pc", bus.pc_o, 32'h100);

        // redirect coincident with rvalid and pop
        lat_lo = 0; lat_hi = 0;
        k = 0;
        while (!(m_out && r_pend && r_wait == 0 && m_q.size() != 0) && k < 20) begin step(); k++; end
        d_redirect = 1; d_next_pc = 32'h200; step();
        chk("t4_rvalid_at_r", bus.imem_rvalid_i, 1); chk("t4_valid_at_r", bus.valid_o, 1);
        d_redirect = 0;
        step(); chk("t4_req_r1", bus.imem_req_o, 1); chk("t4_addr_r1", bus.imem_addr_o, 32'h200);
                chk("t4_valid_r1", bus.valid_o, 0);
        step(); chk("t4_valid_r2", bus.valid_o, 0);
        step(); chk("t4_valid_r3", bus.valid_o, 1); chk("t4_pc_r3", bus.pc_o, 32'h200);

        // grant withheld: address stable, single grant advances by 4
        d_gnt = 0;
        repeat (3) step();
        a0 = bus.fetch_pc_o;
        repeat (4) begin
            step();
            chk("t5_req", bus.imem_req_o, 1);
            chk("t5_addr_stable", bus.imem_addr_o, a0);
            chk("t5_pc_stable", bus.fetch_pc_o, a0);
        end
        d_gnt = 1; step();
        step(); chk("t5_advance", bus.fetch_pc_o, a0 + 32'd4);

        // wrap at top of address space
        d_redirect = 1; d_next_pc = 32'hFFFF_FFFC; step();
        d_redirect = 0;
        step(); chk("t6_req", bus.imem_req_o, 1); chk("t6_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        step(); chk("t6_wrap", bus.fetch_pc_o, 32'h0);

        // randomized traffic
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            d_redirect = ($urandom % 100) < 4;
            case ($urandom % 4)
                0:       d_next_pc = 32'hFFFF_FFF8;
                1:       d_next_pc = $urandom & 32'h0000_FFFE;
                default: d_next_pc = $urandom & 32'hFFFF_FFFE;
            endcase
            d_gnt   = ($urandom % 100) < 70;
            d_ready = ($urandom % 100) < 60;
            step();
        end

        // asynchronous reset mid-burst
        d_redirect = 0; d_gnt = 1; d_ready = 0; lat_lo = 0; lat_hi = 0;
        repeat (5) step();
        d_rst = 1; rst = 1;
        #1;
        chk("areset_req", bus.imem_req_o, 0);
        chk("areset_valid", bus.valid_o, 0);
        chk("areset_fetch_pc", bus.fetch_pc_o, BOOT);
        model_reset();
        step(); step();
        d_rst = 0; d_ready = 1;
        step(); chk("post_reset_addr", bus.imem_addr_o, BOOT);
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
